// File: rtl/sram_tgt_pkg.sv
// Shared state encoding and default geometry for the SRAM-bus target.
package sram_tgt_pkg;
   localparam int unsigned AW_DEF   = 17;
   localparam int unsigned SYNC_DEF = 2;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_DRV,
      WR_HOLD,
      WR_WAIT
   } state_t;
endpackage

// File: rtl/sram_tgt_sync.sv
// Width x depth flop-chain synchronizer with a per-instance reset value.
module sram_tgt_sync
   import sram_tgt_pkg::*;
#(
   parameter int unsigned   W       = 1,
   parameter int unsigned   DEPTH   = SYNC_DEF,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_chain [DEPTH];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_chain[i] <= RST_VAL;
      end else begin
         r_chain[0] <= i_d;
         for (int unsigned i = 1; i < DEPTH; i++) r_chain[i] <= r_chain[i-1];
      end
   end

   assign o_q = r_chain[DEPTH-1];
endmodule

// File: rtl/sram_target.sv
// Async SRAM-bus responder bridging host cycles onto a request/ack local bus.
// Define SRAM_TGT_WAIT_EN to add the active-low sr_wait stretch output.
module sram_target
   import sram_tgt_pkg::*;
#(
   parameter int unsigned AW   = AW_DEF,
   parameter int unsigned SYNC = SYNC_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sr_cs,
   input  logic          sr_we,
   input  logic          sr_oe,
   input  logic [AW-1:0] sr_adr,
   inout  wire  [7:0]    sr_dio,
   output logic          lb_go,
   output logic          lb_wr,
   output logic [AW-1:0] lb_adr,
   output logic [7:0]    lb_dat,
   input  logic [7:0]    lb_rdt,
   input  logic          lb_ack
`ifdef SRAM_TGT_WAIT_EN
   ,
   output logic          sr_wait
`endif
);
   logic [2:0]    w_ctrl_s;
   logic [AW+7:0] w_data_s;
   logic          w_cs_s, w_we_s, w_oe_s;
   logic [AW-1:0] w_adr_s;
   logic [7:0]    w_dio_s;
   logic          w_drive;

   state_t        r_state;
   logic          r_lb_go, r_lb_wr, r_drive_en;
   logic [AW-1:0] r_lb_adr;
   logic [7:0]    r_lb_dat, r_rd_q;

   sram_tgt_sync #(.W(3), .DEPTH(SYNC), .RST_VAL(3'b111)) u_sync_ctrl (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   ({sr_cs, sr_we, sr_oe}),
      .o_q   (w_ctrl_s)
   );

   sram_tgt_sync #(.W(AW+8), .DEPTH(SYNC), .RST_VAL('0)) u_sync_data (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   ({sr_adr, sr_dio}),
      .o_q   (w_data_s)
   );

   assign {w_cs_s, w_we_s, w_oe_s} = w_ctrl_s;
   assign {w_adr_s, w_dio_s}       = w_data_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_lb_go    <= 1'b0;
         r_lb_wr    <= 1'b0;
         r_lb_adr   <= '0;
         r_lb_dat   <= '0;
         r_drive_en <= 1'b0;
         r_rd_q     <= '0;
      end else begin
         r_lb_go <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_cs_s && !w_we_s) begin
                  r_state <= WR_HOLD;
               end else if (!w_cs_s && !w_oe_s) begin
                  r_lb_adr <= w_adr_s;
                  r_lb_go  <= 1'b1;
                  r_lb_wr  <= 1'b0;
                  r_state  <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               // A write that began while the read was outstanding wins; the read data is dropped.
               if (lb_ack) begin
                  if (!w_we_s) begin
                     r_state <= WR_HOLD;
                  end else begin
                     r_rd_q     <= lb_rdt;
                     r_drive_en <= 1'b1;
                     r_state    <= RD_DRV;
                  end
               end
            end
            RD_DRV: begin
               if (!w_cs_s && !w_oe_s && (w_adr_s != r_lb_adr)) begin
                  r_drive_en <= 1'b0;
                  r_lb_adr   <= w_adr_s;
                  r_lb_go    <= 1'b1;
                  r_lb_wr    <= 1'b0;
                  r_state    <= RD_WAIT;
               end else if (w_cs_s || w_oe_s) begin
                  r_drive_en <= 1'b0;
                  r_state    <= IDLE;
               end else if (!w_we_s) begin
                  r_drive_en <= 1'b0;
                  r_state    <= WR_HOLD;
               end
            end
            WR_HOLD: begin
               // The sample taken alongside the strobe rise is skipped so zero data hold is safe.
               if (w_we_s || w_cs_s) begin
                  r_lb_go <= 1'b1;
                  r_lb_wr <= 1'b1;
                  r_state <= WR_WAIT;
               end else begin
                  r_lb_adr <= w_adr_s;
                  r_lb_dat <= w_dio_s;
               end
            end
            WR_WAIT: begin
               if (lb_ack) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_drive = r_drive_en & ~sr_cs & ~sr_oe & sr_we;
   assign sr_dio  = w_drive ? r_rd_q : 'z;

   assign lb_go  = r_lb_go;
   assign lb_wr  = r_lb_wr;
   assign lb_adr = r_lb_adr;
   assign lb_dat = r_lb_dat;

`ifdef SRAM_TGT_WAIT_EN
   assign sr_wait = ~((r_state == RD_WAIT) || (r_state == WR_WAIT));
`endif
endmodule
